alu_cmd_seq: RTL
================

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, command-FIFO entries (power of 2, >= 2).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  command offered.
REQ-005 The block SHALL have port in_ready  output  1  command FIFO can accept.
REQ-006 The block SHALL have port in_cmd  input  4  command code (REQ-012).
REQ-007 The block SHALL have port in_data  input  32  command operand.
REQ-008 The block SHALL have port out_valid  output  1  result word offered.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 The block SHALL have port out_data  output  32  result word (accumulator snapshot).
REQ-011 The block SHALL have ports count  output  $clog2(DEPTH)+1  FIFO occupancy, and err  output  1  sticky reserved-opcode flag.

Function
REQ-012 Commands SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SRL, 0101 SRA (acc <= alu(A=acc, B=operand, ALUOp=cmd[2:0])); 1000 LOAD (acc <= operand); 1001 EMIT; all other codes reserved.
REQ-013 ALU semantics: 32-bit wrap-around add/sub, bitwise and/or, SRL = A >> B[4:0], SRA = A >>> B[4:0] signed; B[31:5] ignored for shifts.
REQ-014 A command SHALL be written into the FIFO on a rising edge where in_valid && in_ready; in_ready = (count < DEPTH), no same-cycle pop bypass when full.
REQ-015 FSM states RUN and HOLD; RUN with FIFO non-empty SHALL retire the head command in exactly one cycle (pop + acc update on the same edge).
REQ-016 Back-to-back ALU/LOAD commands SHALL retire at one per cycle; the second command sees the acc written by the first.
REQ-017 EMIT in RUN SHALL pop, register out_data <= acc, set out_valid, transition to HOLD; acc unchanged.
REQ-018 In HOLD no command SHALL retire; out_valid and out_data SHALL remain stable until out_valid && out_ready, then out_valid clears and FSM returns to RUN on that edge.
REQ-019 Reserved codes SHALL be popped in one cycle with acc unchanged and set err (sticky until reset).
REQ-020 Push and pop on the same edge SHALL leave count unchanged; FIFO pointers wrap modulo DEPTH.
REQ-021 RUN with FIFO empty SHALL hold all state.

Reset
REQ-022 On reset edge: acc = 0, FIFO emptied (count = 0, in_ready = 1), out_valid = 0, out_data = 0, err = 0, FSM = RUN.
REQ-023 Reset SHALL override any simultaneous push, pop or output handshake, including mid-HOLD; an in-flight result is discarded.

Structure
REQ-024 Command codes, ALUOp encodings (3 bits) and FSM state encoding SHALL live in shared package alu_pkg.
REQ-025 Arithmetic SHALL be computed by instantiating the existing combinational sub-module alu (ports A, B, ALUOp, C); no duplicated ALU logic.
REQ-026 FIFO storage and pointers SHALL be inline registers; no second sub-module.

Verification
REQ-027 LOAD F0000000, SRA 0000000F, EMIT -> out_data = FFFFE000, out_valid high, err = 0.
REQ-028 LOAD FFFFFFFF, ADD 00000001, EMIT -> out_data = 00000000 (wrap); LOAD 0, SUB 1, EMIT -> FFFFFFFF.
REQ-029 out_ready held 0 while pushing 5 commands with DEPTH=4 after EMIT -> count reaches 4, in_ready = 0, 5th push blocked, out_data stable; raise out_ready -> FIFO drains one per cycle.
REQ-030 Push code 0110 between LOAD 5 and EMIT -> err = 1, out_data = 00000005.
REQ-031 Assert reset during HOLD with 3 queued commands -> next cycle out_valid = 0, count = 0, acc = 0; EMIT after reset -> out_data = 00000000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the command sequencer: command codes, ALU operation
// codes and FSM states.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SRL = 3'b100,
      ALU_SRA = 3'b101
   } alu_op_e;

   // The low three bits of an ALU command are its ALUOp.
   localparam logic [3:0] CMD_ADD  = 4'b0000;
   localparam logic [3:0] CMD_SUB  = 4'b0001;
   localparam logic [3:0] CMD_AND  = 4'b0010;
   localparam logic [3:0] CMD_OR   = 4'b0011;
   localparam logic [3:0] CMD_SRL  = 4'b0100;
   localparam logic [3:0] CMD_SRA  = 4'b0101;
   localparam logic [3:0] CMD_LOAD = 4'b1000;
   localparam logic [3:0] CMD_EMIT = 4'b1001;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add/sub, and/or, logical and arithmetic right
// shift by B[4:0].
module alu
   import alu_pkg::*;
(
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  ALUOp,
   output logic [31:0] C
);

   always_comb begin
      C = '0;
      case (ALUOp)
         ALU_ADD: C = A + B;
         ALU_SUB: C = A - B;
         ALU_AND: C = A & B;
         ALU_OR:  C = A | B;
         ALU_SRL: C = A >> B[4:0];
         ALU_SRA: C = $unsigned($signed(A) >>> B[4:0]);
         default: C = '0;
      endcase
   end

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer: queues commands in a small FIFO and retires one per
// cycle against an accumulator; EMIT parks a snapshot on the output port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | retire FIFO head each cycle (idle when FIFO empty)
// ST_HOLD | result offered on out_*; nothing retires until it is taken
module alu_cmd_seq
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_cmd,
   input  logic [31:0]              in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [3:0]    fifo_cmd_q  [DEPTH];
   logic [31:0]   fifo_data_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;

   logic [31:0]   acc_q, acc_d;
   logic [31:0]   out_data_q, out_data_d;
   logic          out_valid_q, out_valid_d;
   logic          err_q, err_d;
   state_e        state_q, state_d;

   logic          push, pop;
   logic [3:0]    head_cmd;
   logic [31:0]   head_data;
   logic [31:0]   alu_c;

   assign head_cmd  = fifo_cmd_q[rd_ptr_q];
   assign head_data = fifo_data_q[rd_ptr_q];

   // No pop bypass: a full FIFO refuses the push even if the head retires.
   assign in_ready  = (count_q != DEPTH_C);
   assign push      = in_valid && in_ready;

   alu u_alu (
      .A     (acc_q),
      .B     (head_data),
      .ALUOp (head_cmd[2:0]),
      .C     (alu_c)
   );

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      err_d       = err_q;
      case (state_q)
         ST_RUN: begin
            if (count_q != '0) begin
               pop = 1'b1;
               case (head_cmd)
                  CMD_ADD, CMD_SUB, CMD_AND, CMD_OR, CMD_SRL, CMD_SRA:
                     acc_d = alu_c;
                  CMD_LOAD:
                     acc_d = head_data;
                  CMD_EMIT: begin
                     out_data_d  = acc_q;
                     out_valid_d = 1'b1;
                     state_d     = ST_HOLD;
                  end
                  default:
                     err_d = 1'b1;
               endcase
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         state_q     <= ST_RUN;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q     <= count_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         state_q     <= state_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_cmd_q[wr_ptr_q]  <= in_cmd;
         fifo_data_q[wr_ptr_q] <= in_data;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign count     = count_q;
   assign err       = err_q;

endmodule
